// File: rtl/rom_sync.sv
// rtl/rom_sync.sv - clocked parametrised program ROM serving single-word reads on a shared tri-state bus
// Reads complete after RD_LATENCY cycles; writes are a simulation-only load path; bad requests raise acc_err.
module rom_sync #(
  parameter int    DATA_W     = 8,
  parameter int    ADDR_W     = 16,
  parameter int    DEPTH      = 65536,
  parameter int    RD_LATENCY = 1,
  parameter bit    SIM_WRITE  = 1'b1,
  parameter string INIT_FILE  = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rom_enable_n,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] address_bus,
  inout  wire  [DATA_W-1:0] data_bus,
  output logic              busy,
  output logic              rd_valid,
  output logic              wr_done,
  output logic              acc_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = 2;

  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
    $fatal(1, "rom_sync: RD_LATENCY %0d outside legal range 1..4", RD_LATENCY);
  end

  if (DEPTH < 1 || longint'(DEPTH) > (longint'(1) << ADDR_W)) begin : g_bad_depth
    $fatal(1, "rom_sync: DEPTH %0d does not fit a %0d-bit address", DEPTH, ADDR_W);
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRIVE = 2'd2,
    WRITE = 2'd3
  } state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              wr_done_q, wr_done_d;
  logic              acc_err_q, acc_err_d;
  logic              mem_we;
  logic              addr_in_range;
  logic [IDX_W-1:0]  addr_idx;

  // Widen by one bit so DEPTH == 2**ADDR_W compares correctly.
  assign addr_in_range = ({1'b0, addr_q} < (ADDR_W+1)'(DEPTH));
  assign addr_idx      = addr_q[IDX_W-1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    wr_done_d = 1'b0;
    acc_err_d = 1'b0;
    mem_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rom_enable_n) begin
          if (rd_en && wr_en) begin
            acc_err_d = 1'b1;
          end else if (rd_en) begin
            state_d = READ;
            addr_d  = address_bus;
            cnt_d   = CNT_W'(RD_LATENCY - 1);
          end else if (wr_en) begin
            state_d = WRITE;
            addr_d  = address_bus;
            wdata_d = data_bus;
          end
        end
      end
      READ: begin
        // Losing chip enable mid-read abandons it without ever driving the bus.
        if (rom_enable_n) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = DRIVE;
          rdata_d = addr_in_range ? mem[addr_idx] : '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DRIVE: begin
        state_d = IDLE;
      end
      WRITE: begin
        state_d = IDLE;
        if (SIM_WRITE && addr_in_range) begin
          mem_we    = 1'b1;
          wr_done_d = 1'b1;
        end else begin
          acc_err_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      wr_done_q <= 1'b0;
      acc_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      wr_done_q <= wr_done_d;
      acc_err_q <= acc_err_d;
    end
  end

  // Contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr_idx] <= wdata_q;
    end
  end

  assign busy     = (state_q != IDLE);
  assign rd_valid = (state_q == DRIVE);
  assign wr_done  = wr_done_q;
  assign acc_err  = acc_err_q;
  assign data_bus = rd_valid ? rdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_rom_sync.sv
// tb/tb_rom_sync.sv - randomized self-checking bench for rom_sync over four parameter sets
// Expected values come from an address-keyed memory model and the read/write timing rules.
module tb_rom_sync;

  localparam int N = 4;
  localparam int LAT [N] = '{1, 4, 3, 2};
  localparam int DEP [N] = '{65536, 1024, 65536, 65536};
  localparam bit SWR [N] = '{1'b1, 1'b1, 1'b0, 1'b1};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_n     [N];
  logic        rd       [N];
  logic        wr       [N];
  logic [15:0] addr     [N];
  logic        drv      [N];
  logic [7:0]  dat      [N];
  logic        busy     [N];
  logic        rd_valid [N];
  logic        wr_done  [N];
  logic        acc_err  [N];
  logic [7:0]  bus_obs  [N];

  int checks = 0;
  int errors = 0;
  logic [7:0] mdl [int];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    wire [7:0] bus;
    for (genvar b = 0; b < 8; b++) begin : g_pu
      pullup (bus[b]);
    end
    assign bus        = drv[g] ? dat[g] : 8'bz;
    assign bus_obs[g] = bus;
    rom_sync #(
      .DATA_W    (8),
      .ADDR_W    (16),
      .DEPTH     (DEP[g]),
      .RD_LATENCY(LAT[g]),
      .SIM_WRITE (SWR[g]),
      .INIT_FILE ("")
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rom_enable_n(en_n[g]),
      .rd_en       (rd[g]),
      .wr_en       (wr[g]),
      .address_bus (addr[g]),
      .data_bus    (bus),
      .busy        (busy[g]),
      .rd_valid    (rd_valid[g]),
      .wr_done     (wr_done[g]),
      .acc_err     (acc_err[g])
    );
  end

  function automatic int key(input int i, input logic [15:0] a);
    return i * 65536 + int'(a);
  endfunction

  function automatic bit in_range(input int i, input logic [15:0] a);
    return int'(a) < DEP[i];
  endfunction

  function automatic logic [7:0] exp_rd(input int i, input logic [15:0] a);
    if (!in_range(i, a)) return 8'h00;
    if (mdl.exists(key(i, a))) return mdl[key(i, a)];
    return 8'hxx;
  endfunction

  // Tasks below are entered just after a falling edge and return just after one.
  task automatic do_read(input int i, input logic [15:0] a, input bit noise);
    logic [7:0] exp;
    exp = exp_rd(i, a);
    en_n[i] = 1'b0; rd[i] = 1'b1; wr[i] = 1'b0; addr[i] = a;
    for (int k = 0; k <= LAT[i] + 1; k++) begin
      @(negedge clk);
      checks++;
      if (k < LAT[i]) begin
        if (busy[i] !== 1'b1 || rd_valid[i] !== 1'b0 || bus_obs[i] !== 8'hFF) begin
          errors++;
          $display("FAIL read_wait u%0d @%h k=%0d: busy=%b valid=%b bus=%h, need busy=1 valid=0 bus=FF(Z)",
                   i, a, k, busy[i], rd_valid[i], bus_obs[i]);
        end
      end else if (k == LAT[i]) begin
        if (busy[i] !== 1'b1 || rd_valid[i] !== 1'b1 || bus_obs[i] !== exp) begin
          errors++;
          $display("FAIL read_data u%0d @%h: busy=%b valid=%b bus=%h, need busy=1 valid=1 bus=%h",
                   i, a, busy[i], rd_valid[i], bus_obs[i], exp);
        end
      end else begin
        if (busy[i] !== 1'b0 || rd_valid[i] !== 1'b0 || bus_obs[i] !== 8'hFF) begin
          errors++;
          $display("FAIL read_done u%0d @%h: busy=%b valid=%b bus=%h, need busy=0 valid=0 bus=FF(Z)",
                   i, a, busy[i], rd_valid[i], bus_obs[i]);
        end
      end
      checks++;
      if (acc_err[i] !== 1'b0 || wr_done[i] !== 1'b0) begin
        errors++;
        $display("FAIL read_pulses u%0d @%h k=%0d: acc_err=%b wr_done=%b, need 0 0",
                 i, a, k, acc_err[i], wr_done[i]);
      end
      if (noise && k <= LAT[i]) begin
        rd[i] = 1'($urandom_range(0, 1));
        wr[i] = 1'($urandom_range(0, 1));
      end else begin
        rd[i] = 1'b0;
        wr[i] = 1'b0;
      end
      addr[i] = 16'($urandom);
    end
  endtask

  task automatic do_write(input int i, input logic [15:0] a, input logic [7:0] d);
    bit ok;
    ok = SWR[i] && in_range(i, a);
    en_n[i] = 1'b0; wr[i] = 1'b1; rd[i] = 1'b0; addr[i] = a; drv[i] = 1'b1; dat[i] = d;
    @(negedge clk);
    checks++;
    if (busy[i] !== 1'b1 || rd_valid[i] !== 1'b0 || wr_done[i] !== 1'b0 || acc_err[i] !== 1'b0) begin
      errors++;
      $display("FAIL write_busy u%0d @%h: busy=%b valid=%b wr_done=%b acc_err=%b, need 1 0 0 0",
               i, a, busy[i], rd_valid[i], wr_done[i], acc_err[i]);
    end
    wr[i] = 1'b0; addr[i] = 16'($urandom);
    @(negedge clk);
    drv[i] = 1'b0;
    checks++;
    if (busy[i] !== 1'b0 || wr_done[i] !== ok || acc_err[i] !== !ok) begin
      errors++;
      $display("FAIL write_result u%0d @%h: busy=%b wr_done=%b acc_err=%b, need 0 %b %b",
               i, a, busy[i], wr_done[i], acc_err[i], ok, !ok);
    end
    @(negedge clk);
    checks++;
    if (busy[i] !== 1'b0 || wr_done[i] !== 1'b0 || acc_err[i] !== 1'b0 || bus_obs[i] !== 8'hFF) begin
      errors++;
      $display("FAIL write_after u%0d @%h: busy=%b wr_done=%b acc_err=%b bus=%h, need 0 0 0 FF(Z)",
               i, a, busy[i], wr_done[i], acc_err[i], bus_obs[i]);
    end
    if (ok) mdl[key(i, a)] = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (busy[i] !== 1'b0 || rd_valid[i] !== 1'b0 || wr_done[i] !== 1'b0 ||
          acc_err[i] !== 1'b0 || bus_obs[i] !== 8'hFF) begin
        errors++;
        $display("FAIL reset_state u%0d: busy=%b valid=%b wr_done=%b acc_err=%b bus=%h, need 0 0 0 0 FF(Z)",
                 i, busy[i], rd_valid[i], wr_done[i], acc_err[i], bus_obs[i]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    do_write(0, 16'h1234, 8'hA5);
    do_read(0, 16'h1234, 1'b0);
    do_write(0, 16'hFFFF, 8'h5A);
    do_read(0, 16'hFFFF, 1'b0);
  endtask

  task automatic test_latency4();
    do_write(1, 16'h0000, 8'h3C);
    do_read(1, 16'h0000, 1'b0);
  endtask

  task automatic test_depth();
    do_read(1, 16'h0400, 1'b0);
    do_write(1, 16'h0400, 8'h77);
    do_write(1, 16'h03FF, 8'h81);
    do_read(1, 16'h03FF, 1'b0);
    do_read(1, 16'h0000, 1'b0);
    do_read(1, 16'hFFFF, 1'b0);
  endtask

  task automatic test_both_req();
    for (int i = 0; i < N; i++) begin
      en_n[i] = 1'b0; rd[i] = 1'b1; wr[i] = 1'b1; addr[i] = 16'($urandom);
      @(negedge clk);
      checks++;
      if (busy[i] !== 1'b0 || acc_err[i] !== 1'b1 || rd_valid[i] !== 1'b0 || wr_done[i] !== 1'b0) begin
        errors++;
        $display("FAIL both_req u%0d: busy=%b acc_err=%b valid=%b wr_done=%b, need 0 1 0 0",
                 i, busy[i], acc_err[i], rd_valid[i], wr_done[i]);
      end
      rd[i] = 1'b0; wr[i] = 1'b0;
      @(negedge clk);
      checks++;
      if (busy[i] !== 1'b0 || acc_err[i] !== 1'b0) begin
        errors++;
        $display("FAIL both_req_clear u%0d: busy=%b acc_err=%b, need 0 0", i, busy[i], acc_err[i]);
      end
    end
  endtask

  task automatic test_sw0_write();
    do_write(2, 16'h0100, 8'hC3);
    do_write(2, 16'hFFFF, 8'h11);
  endtask

  task automatic test_abort();
    for (int n = 0; n < 2; n++) begin
      en_n[3] = 1'b0; rd[3] = 1'b1; addr[3] = 16'($urandom);
      @(negedge clk);
      checks++;
      if (busy[3] !== 1'b1) begin
        errors++;
        $display("FAIL abort_accept: busy=%b, need 1", busy[3]);
      end
      rd[3] = 1'b0; en_n[3] = 1'b1;
      repeat (LAT[3] + 2) begin
        @(negedge clk);
        checks++;
        if (busy[3] !== 1'b0 || rd_valid[3] !== 1'b0 || bus_obs[3] !== 8'hFF || acc_err[3] !== 1'b0) begin
          errors++;
          $display("FAIL abort u3: busy=%b valid=%b bus=%h acc_err=%b, need 0 0 FF(Z) 0",
                   busy[3], rd_valid[3], bus_obs[3], acc_err[3]);
        end
      end
      en_n[3] = 1'b0;
    end
    do_write(3, 16'h2222, 8'h96);
    do_read(3, 16'h2222, 1'b1);
  endtask

  task automatic test_back_to_back();
    do_read(0, 16'h1234, 1'b1);
    do_read(0, 16'hFFFF, 1'b1);
    do_read(0, 16'h1234, 1'b0);
    do_read(1, 16'h03FF, 1'b1);
    do_read(1, 16'h0000, 1'b0);
  endtask

  task automatic test_reset_mid_read();
    en_n[2] = 1'b0; rd[2] = 1'b1; addr[2] = 16'h0042;
    @(negedge clk);
    checks++;
    if (busy[2] !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_accept: busy=%b, need 1", busy[2]);
    end
    rd[2] = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy[2] !== 1'b0 || rd_valid[2] !== 1'b0 || bus_obs[2] !== 8'hFF) begin
      errors++;
      $display("FAIL mid_reset_async: busy=%b valid=%b bus=%h, need 0 0 FF(Z)", busy[2], rd_valid[2], bus_obs[2]);
    end
    for (int k = 0; k < LAT[2] + 3; k++) begin
      @(negedge clk);
      if (k == 1) rst_n = 1'b1;
      checks++;
      if (busy[2] !== 1'b0 || rd_valid[2] !== 1'b0 || bus_obs[2] !== 8'hFF) begin
        errors++;
        $display("FAIL mid_reset_after k=%0d: busy=%b valid=%b bus=%h, need 0 0 FF(Z)",
                 k, busy[2], rd_valid[2], bus_obs[2]);
      end
    end
  endtask

  task automatic test_retained();
    do_read(0, 16'h1234, 1'b0);
    do_read(1, 16'h0000, 1'b0);
  endtask

  task automatic test_random(input int i);
    logic [15:0] wa [$];
    logic [15:0] a;
    for (int n = 0; n < 24; n++) begin
      if (wa.size() == 0 || $urandom_range(0, 1) == 1) begin
        if (DEP[i] < 65536) a = 16'($urandom_range(0, DEP[i] + 63));
        else                a = 16'($urandom);
        do_write(i, a, 8'($urandom));
        if (in_range(i, a)) wa.push_back(a);
      end else begin
        a = wa[$urandom_range(0, wa.size() - 1)];
        if (DEP[i] < 65536 && $urandom_range(0, 3) == 0) a = 16'($urandom_range(DEP[i], 65535));
        do_read(i, a, 1'($urandom_range(0, 1)));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      en_n[i] = 1'b1; rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; drv[i] = 1'b0; dat[i] = '0;
    end
    @(negedge clk);
    test_reset();
    test_write_read();
    test_latency4();
    test_depth();
    test_both_req();
    test_sw0_write();
    test_abort();
    test_back_to_back();
    test_reset_mid_read();
    test_retained();
    test_random(0);
    test_random(1);
    test_random(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
